mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit in the execute stage, directly downstream of register_file.
//  Consumes the r1_read/r2_read operands and runs one bit per cycle.
//  Produces write_data, rd and a one-cycle w_en pulse for write-back into register_file.
//  A fixed latency keeps pipeline stall logic simple.
// PARAMETERS
//  XLEN        32  operand/result width; iteration count
//  REG_ADDR_W  5   destination register index width
// PORTS
//  clk       in   1           clock; all state changes on rising edge
//  rst       in   1           reset, synchronous, active-high
//  start     in   1           request; sampled only when busy=0
//  funct3    in   3           000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  op_a      in   XLEN        rs1 value (from r1_read)
//  op_b      in   XLEN        rs2 value (from r2_read)
//  rd_in     in   REG_ADDR_W  destination register of the request
//  flush     in   1           abort in-flight operation (sync)
//  busy      out  1           operation in progress; start ignored
//  done      out  1           one-cycle pulse; result/rd_out valid (drives register_file w_en)
//  result    out  XLEN        result; held until next done
//  rd_out    out  REG_ADDR_W  captured rd_in; held with result
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, result=0, rd_out=0, counter=0. rst dominates flush and start.
//  States: IDLE -> CALC -> FIX -> DONE -> IDLE (or back to CALC on an accepted start).
//  Accept: start=1 and state in {IDLE, DONE} at edge 0.
//   - Latch funct3 and rd_in.
//   - Latch |op_a| and |op_b| per signedness:
//     - MUL/MULH/DIV/REM: both operands signed.
//     - MULHSU: op_a signed, op_b unsigned.
//     - Others: unsigned.
//   - Latch the result sign and the div-by-zero flag (op_b==0).
//   - counter=XLEN; state=CALC.
//  CALC: one iteration per edge, counter decrements. After XLEN iterations (edge XLEN), state=FIX.
//   - Mul: shift-add into a 2*XLEN accumulator.
//   - Div: restoring, 1 quotient bit per edge.
//  FIX (edge XLEN+1): apply result selection and sign correction, register result, state=DONE.
//   - MUL: low half of the product.
//   - MULH*: high half of the signed-corrected 2*XLEN product.
//   - Quotient negated if operand signs differ (signed ops only).
//   - Remainder takes the dividend's sign.
//  DONE: done=1, busy=0 for exactly one cycle.
//   - done is observed XLEN+2 cycles after the start cycle (34 for XLEN=32).
//   - busy=1 throughout CALC and FIX (XLEN+1 cycles).
//  Boundary cases:
//   - Div by zero (override, same latency): DIV/DIVU -> all ones; REM/REMU -> op_a unchanged.
//   - Signed overflow (op_a=-2^(XLEN-1), op_b=-1): DIV -> -2^(XLEN-1); REM -> 0. No trap.
//   - start while busy=1: ignored, no queuing.
//   - start in the DONE cycle: accepted; done still pulses for the finished op.
//   - flush=1: state=IDLE next edge, busy=0, no done for the aborted op.
//     - result/rd_out keep their last value.
//     - flush with start in the same cycle: flush wins, start dropped.
//   - rst mid-operation: all outputs return to reset values next edge; no done.
//  Operands and rd_in are needed only in the accept cycle; later changes have no effect.
// TESTING
//  MUL 7 x 0xFFFFFFFD, rd_in=5 -> result 0xFFFFFFEB, rd_out=5, done exactly 34 cycles after start, 1 cycle wide.
//  MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//  MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
//  start again at cycle 3 of an op -> ignored, one done only.
//  flush at cycle 10 -> busy=0 next cycle, no done; next DIVU 9/3 -> 3 at 34 cycles.
//  rst asserted at cycle 20 of a MUL -> busy/done/result/rd_out=0 next cycle; no done for 40 cycles.

Source files
------------

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative RV32M multiply/divide unit. One multiply (shift-add)
//               or restoring-divide bit per cycle on operand magnitudes, then
//               a single sign-correction/result-select cycle. Fixed latency:
//               done pulses XLEN+2 cycles after the accepting start cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [XLEN-1:0]       op_a,
    input  logic [XLEN-1:0]       op_b,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [XLEN-1:0]       result,
    output logic [REG_ADDR_W-1:0] rd_out
);

    localparam int                 c_cnt_w    = $clog2(XLEN + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(XLEN);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [2:0]              r_func;
    logic [REG_ADDR_W-1:0]   r_rd;
    logic                    r_divz;
    logic                    r_neg_res;   // product / quotient must be negated
    logic                    r_neg_rem;   // remainder takes dividend sign
    logic [XLEN-1:0]         r_hi;        // product high half / partial remainder
    logic [XLEN-1:0]         r_lo;        // multiplier->product low / dividend->quotient
    logic [XLEN-1:0]         r_opnd;      // multiplicand or divisor magnitude

    logic                    w_a_signed;
    logic                    w_b_signed;
    logic                    w_a_neg;
    logic                    w_b_neg;
    logic [XLEN-1:0]         w_abs_a;
    logic [XLEN-1:0]         w_abs_b;
    logic                    w_accept;
    logic [XLEN:0]           w_add;
    logic [XLEN:0]           w_rem_shift;
    logic [XLEN:0]           w_diff;
    logic [2*XLEN-1:0]       w_prod;
    logic [2*XLEN-1:0]       w_prod_s;
    logic [XLEN-1:0]         w_quot;
    logic [XLEN-1:0]         w_rem;
    logic [XLEN-1:0]         w_fix_result;

    // Operand signedness: MULHU/DIVU/REMU unsigned, MULHSU signed rs1 only.
    assign w_a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    assign w_b_signed = w_a_signed && (funct3 != 3'b010);
    assign w_a_neg    = w_a_signed && op_a[XLEN-1];
    assign w_b_neg    = w_b_signed && op_b[XLEN-1];
    assign w_abs_a    = w_a_neg ? -op_a : op_a;
    assign w_abs_b    = w_b_neg ? -op_b : op_b;
    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // One iteration: conditional add for multiply, trial subtract for divide.
    assign w_add       = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
    assign w_rem_shift = {r_hi, r_lo[XLEN-1]};
    assign w_diff      = w_rem_shift - {1'b0, r_opnd};

    // Sign correction of the magnitude results.
    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = r_neg_res ? -w_prod : w_prod;
    assign w_quot   = r_divz ? {XLEN{1'b1}} : (r_neg_res ? -r_lo : r_lo);
    assign w_rem    = r_neg_rem ? -r_hi : r_hi;

    // Result selection by operation.
    always_comb begin
        w_fix_result = w_prod_s[XLEN-1:0];
        case (r_func)
            3'b000:                 w_fix_result = w_prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_result = w_prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_result = w_quot;
            default:                w_fix_result = w_rem;
        endcase
    end

    // Control FSM, datapath iteration and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_func    <= '0;
            r_rd      <= '0;
            r_divz    <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_opnd    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            rd_out    <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (w_accept) begin
            r_state   <= S_CALC;
            r_cnt     <= c_cnt_init;
            r_func    <= funct3;
            r_rd      <= rd_in;
            r_divz    <= (op_b == '0);
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_hi      <= '0;
            r_lo      <= funct3[2] ? w_abs_a : w_abs_b;
            r_opnd    <= funct3[2] ? w_abs_b : w_abs_a;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else begin
            case (r_state)
                S_CALC: begin
                    if (r_func[2]) begin
                        r_hi <= w_diff[XLEN] ? w_rem_shift[XLEN-1:0] : w_diff[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], ~w_diff[XLEN]};
                    end else begin
                        r_hi <= w_add[XLEN:1];
                        r_lo <= {w_add[0], r_lo[XLEN-1:1]};
                    end
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    result  <= w_fix_result;
                    rd_out  <= r_rd;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
